// File: rtl/uart_pkg.sv
// Shared register map and bit positions for the memory-mapped UART controller.
package uart_pkg;

    localparam logic [3:0] UART_STATUS = 4'h0;
    localparam logic [3:0] UART_RX     = 4'h4;
    localparam logic [3:0] UART_TX     = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'hC;

    localparam int unsigned ST_TX_NOT_FULL  = 0;
    localparam int unsigned ST_RX_NOT_EMPTY = 1;
    localparam int unsigned ST_RX_OVERRUN   = 2;
    localparam int unsigned ST_TX_DROP      = 3;
    localparam int unsigned ST_TX_EMPTY     = 4;
    localparam int unsigned ST_RX_COUNT_LSB = 8;

    localparam int unsigned CTRL_CLR_STICKY = 0;
    localparam int unsigned CTRL_FLUSH_RX   = 1;
    localparam int unsigned CTRL_FLUSH_TX   = 2;

endpackage : uart_pkg

// File: rtl/uart_fifo.sv
// Power-of-two circular FIFO with flush, occupancy count and a combinational head byte.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_c,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        empty_c = (count_q == '0);
        do_pop  = pop_i && !empty_c;
        do_push = push_i && (!full_c || do_pop);
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        // Flush overrides any same-cycle push or pop.
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign head_c       = mem_q[rptr_q];
    assign count_o      = count_q;
    assign count_next_c = count_d;

endmodule : uart_fifo

// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the UART serial cores: RX/TX byte FIFOs, status/control registers,
// sticky overrun/drop flags and a registered one-cycle read port.
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq_rx
);

    logic             rd_req, wr_req, ctrl_wr;
    logic             rx_pop, tx_push, tx_pop;
    logic             clr_sticky, flush_rx, flush_tx;
    logic             ovr_set, drop_set;
    logic             ovr_q, ovr_d, drop_q, drop_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d, status_word;

    logic [7:0]       rx_head, tx_head;
    logic [CNT_W-1:0] rx_count, rx_count_next, tx_count, tx_count_next;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             unused_tx;

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_rx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (rx_valid),
        .pop_i        (rx_pop),
        .flush_i      (flush_rx),
        .wdata_i      (rx_data),
        .head_c       (rx_head),
        .count_o      (rx_count),
        .count_next_c (rx_count_next),
        .full_c       (rx_full),
        .empty_c      (rx_empty)
    );

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (tx_push),
        .pop_i        (tx_pop),
        .flush_i      (flush_tx),
        .wdata_i      (req_wdata),
        .head_c       (tx_head),
        .count_o      (tx_count),
        .count_next_c (tx_count_next),
        .full_c       (tx_full),
        .empty_c      (tx_empty)
    );

    assign unused_tx = ^{tx_count, tx_count_next};

    // Request decode and sticky-flag set/clear; a set event beats a same-cycle clear.
    always_comb begin
        rd_req     = req_valid && !req_we;
        wr_req     = req_valid && req_we;
        ctrl_wr    = wr_req && (req_addr == UART_CTRL);
        rx_pop     = rd_req && (req_addr == UART_RX);
        tx_push    = wr_req && (req_addr == UART_TX);
        tx_pop     = !tx_empty && tx_ready;
        clr_sticky = ctrl_wr && req_wdata[CTRL_CLR_STICKY];
        flush_rx   = ctrl_wr && req_wdata[CTRL_FLUSH_RX];
        flush_tx   = ctrl_wr && req_wdata[CTRL_FLUSH_TX];
        ovr_set    = rx_valid && rx_full && !rx_pop && !flush_rx;
        drop_set   = tx_push && tx_full && !tx_pop && !flush_tx;
        ovr_d      = (ovr_q && !clr_sticky) || ovr_set;
        drop_d     = (drop_q && !clr_sticky) || drop_set;
        irq_d      = (rx_count_next != '0);
    end

    always_comb begin
        status_word                              = '0;
        status_word[ST_TX_NOT_FULL]              = !tx_full;
        status_word[ST_RX_NOT_EMPTY]             = !rx_empty;
        status_word[ST_RX_OVERRUN]               = ovr_q;
        status_word[ST_TX_DROP]                  = drop_q;
        status_word[ST_TX_EMPTY]                 = tx_empty;
        status_word[ST_RX_COUNT_LSB +: CNT_W]    = rx_count;
    end

    // Read data samples pre-edge state and holds until the next read.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_req) begin
            case (req_addr)
                UART_STATUS: rdata_d = status_word;
                UART_RX:     rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
                default:     rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            ovr_q   <= 1'b0;
            drop_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ovr_q   <= ovr_d;
            drop_q  <= drop_d;
            irq_q   <= irq_d;
        end
    end

    assign rdata    = rdata_q;
    assign irq_rx   = irq_q;
    assign rx_ready = 1'b1;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_head;

endmodule : uart_mmio_ctrl

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with RX/TX byte scoreboards and a read-result queue.
module tb_uart_mmio_ctrl;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        irq_rx;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_tag_q[$];

    uart_mmio_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .irq_rx    (irq_rx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mmio_write(input logic [3:0] addr, input logic [7:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Issue a read, queue its expected value, and compare once rdata has been registered.
    task automatic mmio_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(tag);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        check(rd_tag_q.pop_front(), rdata, rd_exp_q.pop_front());
    endtask

    task automatic rx_read(input string tag);
        logic [31:0] exp;
        exp = (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
        mmio_read(4'h4, exp, tag);
    endtask

    task automatic tx_write(input logic [7:0] b);
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        mmio_write(4'h8, b);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_rdata", rdata, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_irq", {31'h0, irq_rx}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        mmio_read(4'h0, 32'h0000_0011, "status_after_reset");
        mmio_read(4'h8, 32'h0, "read_tx_reg_zero");

        // TX ordering with single-cycle ready pulses
        tx_write(8'h78);
        tx_write(8'h79);
        tx_write(8'h7a);
        check("tx_valid_loaded", {31'h0, tx_valid}, 32'h1);
        mmio_read(4'h0, 32'h0000_0001, "status_tx3");
        for (int i = 0; i < 3; i++) begin
            check("tx_valid_hold", {31'h0, tx_valid}, 32'h1);
            check("tx_order", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
        check("tx_valid_drained", {31'h0, tx_valid}, 32'h0);
        mmio_read(4'h0, 32'h0000_0011, "status_tx_empty");

        // RX overflow: ninth byte dropped, overrun set
        for (int i = 1; i <= 9; i++) rx_push(8'(i));
        check("irq_full", {31'h0, irq_rx}, 32'h1);
        mmio_read(4'h0, 32'h0000_0817, "status_rx_overrun");
        for (int i = 0; i < 9; i++) rx_read("rx_drain");
        check("irq_empty", {31'h0, irq_rx}, 32'h0);
        mmio_read(4'h0, 32'h0000_0015, "status_overrun_sticky");
        mmio_write(4'hC, 8'h01);
        mmio_read(4'h0, 32'h0000_0011, "status_cleared");

        // Full RX with simultaneous pop and push
        for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        rx_read("rx_pop_push_full");
        rx_valid = 1'b0;
        rx_q.push_back(8'hAA);
        mmio_read(4'h0, 32'h0000_0813, "status_full_no_overrun");
        for (int i = 0; i < 8; i++) rx_read("rx_drain2");
        mmio_read(4'h0, 32'h0000_0011, "status_rx_empty2");

        // TX full: drop sets flag, clear, then flush
        for (int i = 0; i < 8; i++) tx_write(8'h20 + 8'(i));
        tx_write(8'h55);
        mmio_read(4'h0, 32'h0000_0008, "status_tx_drop");
        check("tx_head_after_drop", {24'h0, tx_data}, {24'h0, tx_q[0]});
        mmio_write(4'hC, 8'h01);
        mmio_read(4'h0, 32'h0000_0000, "status_drop_cleared");
        mmio_write(4'hC, 8'h04);
        tx_q.delete();
        check("tx_flushed", {31'h0, tx_valid}, 32'h0);
        mmio_read(4'h0, 32'h0000_0011, "status_tx_flushed");

        // Overrun set and clear in the same cycle: set wins
        for (int i = 0; i < 8; i++) rx_push(8'h30 + 8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        mmio_write(4'hC, 8'h01);
        rx_valid = 1'b0;
        mmio_read(4'h0, 32'h0000_0817, "status_set_wins");
        // Flush with a push into full RX: discarded, no flag
        rx_valid = 1'b1;
        rx_data  = 8'h9A;
        mmio_write(4'hC, 8'h03);
        rx_valid = 1'b0;
        rx_q.delete();
        mmio_read(4'h0, 32'h0000_0011, "status_flush_rx");
        check("irq_after_flush", {31'h0, irq_rx}, 32'h0);

        // Empty RX with simultaneous read and push
        rx_valid = 1'b1;
        rx_data  = 8'h5C;
        rx_read("rx_empty_read_push");
        rx_valid = 1'b0;
        rx_q.push_back(8'h5C);
        mmio_read(4'h0, 32'h0000_0113, "status_count1");
        rx_read("rx_read_5c");

        // Reset mid-drain
        for (int i = 0; i < 6; i++) rx_push(8'h40 + 8'(i));
        rx_read("rx_before_reset");
        mmio_read(4'h0, 32'h0000_0513, "status_count5");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx_q.delete();
        check("irq_after_reset", {31'h0, irq_rx}, 32'h0);
        check("rdata_after_reset", rdata, 32'h0);
        mmio_read(4'h0, 32'h0000_0011, "status_after_midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_mmio_ctrl

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped UART controller that sits between the CPU MMIO decode and the existing uart_transmitter and uart_receiver ready/valid datapath. It buffers received bytes and bytes to send in two FIFOs, and sequences transmit handoff to the serial core. It exposes status, RX data, TX data and control registers with a fixed one-cycle read latency, and keeps sticky overrun and drop flags so software polling loops do not silently lose characters.

Parameters:
DEPTH, 8, entries per FIFO; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy counters

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  MMIO access this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  4  byte offset within UART region (word aligned)
req_wdata  input  8  write data (low byte of store)
rdata  output  32  read data, valid the cycle after the read request
tx_data  output  8  byte to uart_transmitter
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  transmitter accepts byte
rx_data  input  8  byte from uart_receiver
rx_valid  input  1  receiver has byte
rx_ready  output  1  controller accepts byte
irq_rx  output  1  level: RX FIFO non-empty

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset both FIFOs are empty, both sticky flags are 0, rdata=0, tx_valid=0, irq_rx=0, and rx_ready=1.
- Register map:
  - 0x0 STATUS (R): bit0 = TX not full; bit1 = RX not empty; bit2 = rx_overrun (sticky); bit3 = tx_drop (sticky); bit4 = TX empty; bits[8+CNT_W-1:8] = RX count; all other bits 0.
  - 0x4 RX_DATA (R): returns {24'b0, head byte} and pops the head. If RX is empty, returns 0 and does not pop.
  - 0x8 TX_DATA (W): pushes req_wdata. If TX is full, the byte is discarded and tx_drop is set.
  - 0xC CTRL (W): bit0 clears both sticky flags; bit1 flushes RX; bit2 flushes TX.
  - Reads of write-only or unmapped offsets return 0. Writes to read-only or unmapped offsets are ignored.
- Read latency: rdata is registered and reflects pre-edge state at the request cycle, valid exactly one cycle later. rdata holds its value until the next read. Writes produce no response.
- RX path:
  - rx_ready is constantly 1; the controller never back-pressures the receiver.
  - Push when rx_valid is high. If RX is full and no CPU pop occurs in the same cycle, the byte is dropped and rx_overrun is set.
  - Full RX with a simultaneous CPU pop and rx push: both happen, count is unchanged, no overrun.
  - Empty RX with a simultaneous read and push: the read returns 0, and the pushed byte is stored (count becomes 1).
- TX path:
  - tx_valid = TX non-empty; tx_data = head byte, combinational from FIFO storage.
  - Pop on tx_valid && tx_ready.
  - Full TX with a simultaneous CPU write and pop: the write is accepted, no drop.
  - tx_data/tx_valid hold stable until accepted.
- Flush:
  - Flush empties the target FIFO at the edge; pointers and count go to 0.
  - Flush takes priority over a same-cycle push or pop on that FIFO. A discarded byte does not set a sticky flag.
- Sticky flags: a same-cycle clear (CTRL bit0) and set event leaves the flag set; set wins.
- Pointers: wrap modulo DEPTH. Count ranges 0..DEPTH. Full = (count == DEPTH).
- irq_rx: registered from the next-state RX count, so it asserts the cycle after the first push.
- Reset mid-transfer: all contents are lost. tx_valid drops the cycle after rst is sampled, which may truncate the transmitter handoff; this is acceptable.

Decomposition:
- Shared package (uart_pkg): register offsets (UART_STATUS=4'h0, UART_RX=4'h4, UART_TX=4'h8, UART_CTRL=4'hC), STATUS bit indices, CTRL bit indices.
- One sub-module: uart_fifo (parameterised DEPTH and WIDTH=8, push/pop/flush, count, full/empty, head data). Instantiated twice.

Test Plan:
- Reset, then read STATUS -> next-cycle rdata = 32'h0000_0011 (TX not full, TX empty); tx_valid=0; irq_rx=0.
- Write 0x78, 0x79, 0x7a to TX with tx_ready held low -> tx_valid=1, tx_data=0x78. Pulse tx_ready three single cycles -> bytes presented in order 0x78, 0x79, 0x7a, then tx_valid=0 and STATUS bit4=1.
- Push 9 RX bytes 0x01..0x09 with DEPTH=8, no reads -> STATUS = 8 in bits[11:8], bit2=1. Eight RX_DATA reads return 0x01..0x08; a ninth read returns 0.
- Fill RX to 8, then in one cycle apply rx_valid=1 (byte 0xAA) and an RX_DATA read -> rdata=first byte, count stays 8, bit2 stays 0, and 0xAA appears as the last byte read.
- Fill TX with tx_ready=0, write a 9th byte 0x55 -> dropped and bit3=1. Write CTRL=1 -> bits2/3 cleared. Write CTRL=4 -> tx_valid=0 the next cycle.
- Assert rst in the middle of an RX drain with count 5 -> the next STATUS read = 32'h0000_0011, and irq_rx deasserted.
